// File: rtl/tx_timer_mc.sv
// tx_timer_mc: multi-channel timeout timer for the alink TX path.
// NCH independent counters run against one shared timeout. Each channel can
// run one-shot or auto-reload, and reports busy, a one-cycle expiry pulse
// and a sticky expiry flag. All outputs come straight from flops.
module tx_timer_mc #(
  parameter int NCH = 4,
  parameter int TW  = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_flush,
  input  logic [31:0]          reg_tout,
  input  logic [NCH-1:0]       reg_periodic,
  input  logic [NCH-1:0]       reg_sts_clr,
  input  logic [NCH-1:0]       timer_start,
  input  logic [NCH-1:0]       timer_stop,
  output logic [NCH-1:0]       timer_busy,
  output logic [NCH-1:0]       timer_expire,
  output logic [NCH-1:0]       timer_sts,
  output logic [32*NCH-1:0]    timer_cnt
);

  // Only the low TW bits of the shared timeout are meaningful.
  logic [TW-1:0]  tout_eff;
  logic           tout_off;
  logic           unused_tout_bits;

  assign tout_eff         = reg_tout[TW-1:0];
  assign tout_off         = (tout_eff == '0);
  assign unused_tout_bits = ^reg_tout;

  logic [TW-1:0]  cnt_q [NCH];
  logic [TW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] busy_q, busy_d;
  logic [NCH-1:0] exp_q,  exp_d;
  logic [NCH-1:0] sts_q,  sts_d;
  logic [NCH-1:0] term;

  // Per-channel next state: flush > stop > start > disabled > terminal > increment.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      busy_d[i] = busy_q[i];
      exp_d[i]  = 1'b0;
      sts_d[i]  = sts_q[i];
      term[i]   = 1'b0;

      if (reg_flush) begin
        cnt_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else if (timer_stop[i]) begin
        cnt_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else if (timer_start[i] && !tout_off) begin
        // A restart also swallows a terminal count that lands on this edge.
        cnt_d[i]  = TW'(1);
        busy_d[i] = 1'b1;
      end else if (tout_off) begin
        // A zero timeout disables the timer; running channels drop silently.
        cnt_d[i]  = '0;
        busy_d[i] = 1'b0;
      end else if (busy_q[i]) begin
        // >= so that shrinking the timeout below the count expires at once.
        if (cnt_q[i] >= tout_eff) begin
          term[i]  = 1'b1;
          exp_d[i] = 1'b1;
          if (reg_periodic[i]) begin
            cnt_d[i]  = TW'(1);
            busy_d[i] = 1'b1;
          end else begin
            cnt_d[i]  = '0;
            busy_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + TW'(1);
        end
      end

      // Sticky flag: flush clears, expiry beats a same-cycle software clear.
      if (reg_flush) begin
        sts_d[i] = 1'b0;
      end else if (term[i]) begin
        sts_d[i] = 1'b1;
      end else if (reg_sts_clr[i]) begin
        sts_d[i] = 1'b0;
      end
    end
  end

  // Channel state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      busy_q <= '0;
      exp_q  <= '0;
      sts_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q <= busy_d;
      exp_q  <= exp_d;
      sts_q  <= sts_d;
    end
  end

  assign timer_busy   = busy_q;
  assign timer_expire = exp_q;
  assign timer_sts    = sts_q;

  // Pack each TW-bit count into its zero-extended 32-bit lane.
  always_comb begin
    timer_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      timer_cnt[32*i +: TW] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_tx_timer_mc.sv
// tb_tx_timer_mc: directed test-plan sequences plus randomized traffic on a
// 4-channel/26-bit timer, checked cycle by cycle against a behavioural model,
// and a long-timeout check on a 1-channel/8-bit instance.
module tb_tx_timer_mc;
  localparam int NCH = 4;
  localparam int TW  = 26;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reg_flush = 1'b0;
  logic [31:0]       reg_tout = '0;
  logic [NCH-1:0]    reg_periodic = '0;
  logic [NCH-1:0]    reg_sts_clr = '0;
  logic [NCH-1:0]    timer_start = '0;
  logic [NCH-1:0]    timer_stop = '0;
  logic [NCH-1:0]    timer_busy, timer_expire, timer_sts;
  logic [32*NCH-1:0] timer_cnt;

  logic [31:0]       b_tout = '0;
  logic [0:0]        b_start = '0;
  logic [0:0]        b_busy, b_exp, b_sts;
  logic [31:0]       b_cnt;

  tx_timer_mc #(.NCH(NCH), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .reg_flush(reg_flush), .reg_tout(reg_tout),
    .reg_periodic(reg_periodic), .reg_sts_clr(reg_sts_clr),
    .timer_start(timer_start), .timer_stop(timer_stop),
    .timer_busy(timer_busy), .timer_expire(timer_expire),
    .timer_sts(timer_sts), .timer_cnt(timer_cnt)
  );

  tx_timer_mc #(.NCH(1), .TW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .reg_flush(1'b0), .reg_tout(b_tout),
    .reg_periodic(1'b0), .reg_sts_clr(1'b0),
    .timer_start(b_start), .timer_stop(1'b0),
    .timer_busy(b_busy), .timer_expire(b_exp),
    .timer_sts(b_sts), .timer_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: one record per channel.
  longint unsigned m_cnt  [NCH];
  bit              m_busy [NCH];
  bit              m_exp  [NCH];
  bit              m_sts  [NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0; m_busy[i] = 0; m_exp[i] = 0; m_sts[i] = 0;
    end
  endtask

  // Apply one clock edge's worth of the timer rules to the model.
  task automatic model_step();
    longint unsigned tout;
    bit expired;
    tout = longint'(reg_tout) % (64'd1 << TW);
    for (int i = 0; i < NCH; i++) begin
      expired = 0;
      if (reg_flush || timer_stop[i]) begin
        m_cnt[i] = 0; m_busy[i] = 0; m_exp[i] = 0;
      end else if (timer_start[i] && tout != 0) begin
        m_cnt[i] = 1; m_busy[i] = 1; m_exp[i] = 0;
      end else if (tout == 0) begin
        m_cnt[i] = 0; m_busy[i] = 0; m_exp[i] = 0;
      end else if (m_busy[i] && m_cnt[i] >= tout) begin
        expired  = 1;
        m_exp[i] = 1;
        m_busy[i] = reg_periodic[i];
        m_cnt[i]  = reg_periodic[i] ? 1 : 0;
      end else if (m_busy[i]) begin
        m_cnt[i] = m_cnt[i] + 1; m_exp[i] = 0;
      end else begin
        m_exp[i] = 0;
      end
      if (reg_flush)           m_sts[i] = 0;
      else if (expired)        m_sts[i] = 1;
      else if (reg_sts_clr[i]) m_sts[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("cnt%0d", i),  timer_cnt[32*i +: 32], m_cnt[i]);
      chk($sformatf("busy%0d", i), timer_busy[i],   m_busy[i]);
      chk($sformatf("exp%0d", i),  timer_expire[i], m_exp[i]);
      chk($sformatf("sts%0d", i),  timer_sts[i],    m_sts[i]);
    end
  endtask

  // One clock: edge, model update, compare 1ns later, then clear pulse inputs.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    timer_start = '0; timer_stop = '0; reg_sts_clr = '0; reg_flush = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", timer_busy, '0);
    chk("rst_exp",  timer_expire, '0);
    chk("rst_sts",  timer_sts, '0);
    chk("rst_cnt",  timer_cnt, '0);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n;
  logic [31:0] last_b_cnt;

  initial begin
    model_reset();
    #1;
    chk("por_busy", timer_busy, '0);
    chk("por_exp",  timer_expire, '0);
    chk("por_sts",  timer_sts, '0);
    chk("por_cnt",  timer_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One-shot, tout=3 on ch0.
    reg_tout = 32'd3;
    timer_start[0] = 1'b1;
    cycle();
    chk("os_cnt1", timer_cnt[31:0], 32'd1);
    cycle(); cycle();
    chk("os_cnt3", timer_cnt[31:0], 32'd3);
    chk("os_noexp", timer_expire[0], 1'b0);
    cycle();
    chk("os_exp", timer_expire[0], 1'b1);
    chk("os_idle", timer_busy[0], 1'b0);
    cycle();
    chk("os_exp_pulse", timer_expire[0], 1'b0);
    chk("os_sts_held", timer_sts[0], 1'b1);
    reg_sts_clr[0] = 1'b1;
    cycle();
    chk("os_sts_clr", timer_sts[0], 1'b0);

    // Periodic, tout=2 on ch1, then stop.
    reg_tout = 32'd2;
    reg_periodic[1] = 1'b1;
    timer_start[1] = 1'b1;
    cycle();
    repeat (10) cycle();
    timer_stop[1] = 1'b1;
    cycle();
    chk("per_stop_busy", timer_busy[1], 1'b0);
    repeat (4) cycle();
    reg_periodic[1] = 1'b0;

    // Restart at terminal count, tout=5 on ch2.
    reg_tout = 32'd5;
    timer_start[2] = 1'b1;
    cycle();
    repeat (4) cycle();
    chk("rs_cnt5", timer_cnt[95:64], 32'd5);
    timer_start[2] = 1'b1;
    cycle();
    chk("rs_noexp", timer_expire[2], 1'b0);
    chk("rs_cnt1", timer_cnt[95:64], 32'd1);
    repeat (5) cycle();
    chk("rs_exp", timer_expire[2], 1'b1);

    // Shrink timeout under a running count, then disable with tout=0.
    reg_tout = 32'd20;
    timer_start[3] = 1'b1;
    cycle();
    repeat (9) cycle();
    chk("sh_cnt10", timer_cnt[127:96], 32'd10);
    reg_tout = 32'd4;
    cycle();
    chk("sh_exp", timer_expire[3], 1'b1);
    chk("sh_idle", timer_busy[3], 1'b0);
    repeat (2) cycle();
    reg_tout = 32'd0;
    timer_start[3] = 1'b1;
    cycle();
    chk("dis_busy", timer_busy[3], 1'b0);
    cycle();

    // Flush against a terminal and a status clear; then async reset mid-count.
    reg_tout = 32'd3;
    timer_start = '1;
    cycle();
    cycle(); cycle();
    reg_flush = 1'b1;
    reg_sts_clr[1] = 1'b1;
    cycle();
    chk("fl_busy", timer_busy, '0);
    chk("fl_sts", timer_sts, '0);
    chk("fl_exp", timer_expire, '0);
    timer_start = '1;
    cycle(); cycle();
    async_reset();

    // Narrow instance: tout=0x1FF truncates to 255.
    b_tout = 32'h1FF;
    b_start = 1'b1;
    cycle();
    b_start = 1'b0;
    chk("w8_cnt1", b_cnt, 32'd1);
    n = 0;
    last_b_cnt = b_cnt;
    while (b_exp !== 1'b1 && n < 400) begin
      last_b_cnt = b_cnt;
      cycle();
      n++;
    end
    chk("w8_latency", n, 255);
    chk("w8_lastcnt", last_b_cnt, 32'd255);
    chk("w8_busy", b_busy, 1'b0);
    chk("w8_sts", b_sts, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0)
        reg_tout = $urandom_range(0, 7) | ($urandom_range(0, 3) == 0 ? 32'h0400_0000 : 32'h0);
      if ($urandom_range(0, 31) == 0) reg_periodic = NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        timer_start[i] = ($urandom_range(0, 5) == 0);
        timer_stop[i]  = ($urandom_range(0, 19) == 0);
        reg_sts_clr[i] = ($urandom_range(0, 7) == 0);
      end
      reg_flush = ($urandom_range(0, 59) == 0);
      cycle();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
